// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the byte-serial wide adder: byte width, FSM states
// and the index-width helper.
package adder_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte-index width; never below one bit so NBYTES=1 still has a legal vector.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/byte_add_unit.sv
// Combinational 8-bit ripple adder with carry in/out; the only adder in the
// wide-add datapath.
module byte_add_unit
  import adder_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign s       = total_s[BYTE_W-1:0];
  assign cout    = total_s[BYTE_W];

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// Byte-serial wide adder: one byte adder sequenced LSB-first over NBYTES cycles.
// Optional subtraction (a + ~b + 1) is built when the macro SUB_EN is defined.
module multi_byte_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     op_sub,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  idx_r;
  logic              carry_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      work_r;
  logic [W-1:0]      sum_r;
  logic              cout_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic [BYTE_W-1:0] a_byte_s;
  logic [BYTE_W-1:0] b_sel_s;
  logic [BYTE_W-1:0] b_byte_s;
  logic [BYTE_W-1:0] s_byte_s;
  logic              co_byte_s;
  logic              init_carry_s;

`ifdef SUB_EN
  logic              op_r;

  assign init_carry_s = op_sub;
`else
  logic              unused_op_s;

  assign unused_op_s  = op_sub;
  assign init_carry_s = 1'b0;
`endif

  assign a_byte_s = a_r[idx_r*BYTE_W +: BYTE_W];
  assign b_sel_s  = b_r[idx_r*BYTE_W +: BYTE_W];

  // Operand B byte, inverted when a subtraction is in flight.
  always_comb begin
    b_byte_s = b_sel_s;
`ifdef SUB_EN
    if (op_r) begin
      b_byte_s = ~b_sel_s;
    end else begin
      b_byte_s = b_sel_s;
    end
`endif
  end

  byte_add_unit u_byte_add (
    .a    (a_byte_s),
    .b    (b_byte_s),
    .cin  (carry_r),
    .s    (s_byte_s),
    .cout (co_byte_s)
  );

  // Next-state logic for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = ADD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, per-byte accumulation and carry chaining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
`ifdef SUB_EN
      op_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx_r   <= '0;
            carry_r <= init_carry_s;
`ifdef SUB_EN
            op_r    <= op_sub;
`endif
          end
        end
        ADD: begin
          work_r[idx_r*BYTE_W +: BYTE_W] <= s_byte_s;
          carry_r <= co_byte_s;
          if (idx_r == LAST_IDX) begin
            idx_r <= '0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and status outputs; sum/cout move only on a completed operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r   <= '0;
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      if (state_r == DONE) begin
        sum_r  <= work_r;
        cout_r <= carry_r;
      end
      done_r  <= (state_r == DONE);
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s == ADD);
    end
  end

  assign sum   = sum_r;
  assign cout  = cout_r;
  assign done  = done_r;
  assign ready = ready_r;
  assign busy  = busy_r;

endmodule
